// File: rtl/apu_frame_seq.sv
// ---------------------------------------------------------------------------
// apu_frame_seq -- APU frame sequencer.
//
// Divides the 512 Hz DIV bit-4 square into the three channel housekeeping
// strobes. Every falling edge of div_bit (a "tick") advances an 8-step
// counter while the APU is enabled. The step that was current when the tick
// arrived selects which strobes fire:
//   len_clk   (256 Hz) steps 0,2,4,6
//   sweep_clk (128 Hz) steps 2,6
//   env_clk   ( 64 Hz) step 7
// Each strobe is registered and lasts exactly one cycle, one cycle after
// the tick.
//
// Ports:
//   ajer_2mhz   in   sole clock, rising edge
//   apu_reset   in   synchronous active-high reset
//   apu_en      in   APU master enable level
//   div_bit     in   DIV bit-4 level
//   step_wr     in   step load strobe      (FRAME_SEQ_STEP_WR_EN only)
//   step_d[2:0] in   step load value       (FRAME_SEQ_STEP_WR_EN only)
//   len_clk     out  length counter strobe
//   sweep_clk   out  channel-1 sweep strobe
//   env_clk     out  volume envelope strobe
//   frame_step  out  current step 0..7
//   len_next_n  out  high when the next tick will not clock length
//
// Configuration macro: FRAME_SEQ_STEP_WR_EN adds the step load port pair.
// ---------------------------------------------------------------------------
module apu_frame_seq (
    input  logic       ajer_2mhz,
    input  logic       apu_reset,
    input  logic       apu_en,
    input  logic       div_bit,
`ifdef FRAME_SEQ_STEP_WR_EN
    input  logic       step_wr,
    input  logic [2:0] step_d,
`endif
    output logic       len_clk,
    output logic       sweep_clk,
    output logic       env_clk,
    output logic [2:0] frame_step,
    output logic       len_next_n
);

    logic       div_q_r;
    logic [2:0] step_r;
    logic       len_r;
    logic       sweep_r;
    logic       env_r;

    logic       tick_s;
    logic       load_s;
    logic [2:0] load_val_s;
    logic [2:0] step_nxt_s;
    logic       len_nxt_s;
    logic       sweep_nxt_s;
    logic       env_nxt_s;

`ifdef FRAME_SEQ_STEP_WR_EN
    assign load_s     = step_wr;
    assign load_val_s = step_d;
`else
    assign load_s     = 1'b0;
    assign load_val_s = 3'd0;
`endif

    // Falling edge of div_bit, seen in the same cycle the level drops.
    always_comb begin
        tick_s = div_q_r & ~div_bit;
    end

    // Next step: a load wins over everything but reset; a disabled APU
    // pins the step at 0 regardless of ticks.
    always_comb begin
        step_nxt_s = step_r;
        if (load_s) begin
            step_nxt_s = load_val_s;
        end else if (!apu_en) begin
            step_nxt_s = 3'd0;
        end else if (tick_s) begin
            step_nxt_s = step_r + 3'd1;
        end else begin
            step_nxt_s = step_r;
        end
    end

    // Strobe decode from the pre-increment step of a qualifying tick.
    always_comb begin
        len_nxt_s   = 1'b0;
        sweep_nxt_s = 1'b0;
        env_nxt_s   = 1'b0;
        if (tick_s && apu_en && !load_s) begin
            case (step_r)
                3'd0, 3'd4: begin
                    len_nxt_s = 1'b1;
                end
                3'd2, 3'd6: begin
                    len_nxt_s   = 1'b1;
                    sweep_nxt_s = 1'b1;
                end
                3'd7: begin
                    env_nxt_s = 1'b1;
                end
                default: begin
                    len_nxt_s   = 1'b0;
                    sweep_nxt_s = 1'b0;
                    env_nxt_s   = 1'b0;
                end
            endcase
        end else begin
            len_nxt_s   = 1'b0;
            sweep_nxt_s = 1'b0;
            env_nxt_s   = 1'b0;
        end
    end

    // State register; reset loads div_q from div_bit so release cannot
    // fabricate a tick out of a stale sample.
    always_ff @(posedge ajer_2mhz) begin
        if (apu_reset) begin
            div_q_r <= div_bit;
            step_r  <= 3'd0;
            len_r   <= 1'b0;
            sweep_r <= 1'b0;
            env_r   <= 1'b0;
        end else begin
            div_q_r <= div_bit;
            step_r  <= step_nxt_s;
            len_r   <= len_nxt_s;
            sweep_r <= sweep_nxt_s;
            env_r   <= env_nxt_s;
        end
    end

    // Output mapping; len_next_n is simply "current step is odd".
    always_comb begin
        len_clk    = len_r;
        sweep_clk  = sweep_r;
        env_clk    = env_r;
        frame_step = step_r;
        len_next_n = step_r[0];
    end

endmodule

// File: tb/tb_apu_frame_seq.sv
// ---------------------------------------------------------------------------
// tb_apu_frame_seq -- self-checking bench for apu_frame_seq.
// A behavioural model (step counter as an integer mod 8, strobes from
// arithmetic on the step) predicts outputs after every clock edge.
// ---------------------------------------------------------------------------
module tb_apu_frame_seq;

    logic       clk;
    logic       apu_reset;
    logic       apu_en;
    logic       div_bit;
    logic       step_wr;
    logic [2:0] step_d;
    logic       len_clk;
    logic       sweep_clk;
    logic       env_clk;
    logic [2:0] frame_step;
    logic       len_next_n;

`ifdef FRAME_SEQ_STEP_WR_EN
    localparam bit WR_EN = 1'b1;
`else
    localparam bit WR_EN = 1'b0;
`endif

    apu_frame_seq dut (
        .ajer_2mhz  (clk),
        .apu_reset  (apu_reset),
        .apu_en     (apu_en),
        .div_bit    (div_bit),
`ifdef FRAME_SEQ_STEP_WR_EN
        .step_wr    (step_wr),
        .step_d     (step_d),
`endif
        .len_clk    (len_clk),
        .sweep_clk  (sweep_clk),
        .env_clk    (env_clk),
        .frame_step (frame_step),
        .len_next_n (len_next_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model state
    int   m_step = 0;
    bit   m_prev_div = 1'b0;
    bit   e_len = 1'b0;
    bit   e_sweep = 1'b0;
    bit   e_env = 1'b0;

    // expected strobe tables indexed by pre-increment step
    logic [7:0] len_tab   = 8'b0101_0101;
    logic [7:0] sweep_tab = 8'b0100_0100;
    logic [7:0] env_tab   = 8'b1000_0000;

    // Drive one cycle of inputs, advance the model, sample after the edge.
    task automatic drive(input bit en, input bit dv, input bit rst,
                         input bit wr, input logic [2:0] d);
        bit tick;
        @(negedge clk);
        apu_en    = en;
        div_bit   = dv;
        apu_reset = rst;
        step_wr   = wr;
        step_d    = d;
        tick = m_prev_div && !dv;
        e_len = 1'b0; e_sweep = 1'b0; e_env = 1'b0;
        if (rst) begin
            m_step = 0;
        end else if (WR_EN && wr) begin
            m_step = int'(d);
        end else if (!en) begin
            m_step = 0;
        end else if (tick) begin
            e_len   = (m_step % 2) == 0;
            e_sweep = (m_step == 2) || (m_step == 6);
            e_env   = (m_step == 7);
            m_step  = (m_step + 1) % 8;
        end
        m_prev_div = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 4; i++) begin
            drive($urandom_range(0, 1), (i == 3) ? 1'b0 : 1'($urandom_range(0, 1)), 1'b1, 1'b0, 3'd0);
            total++;
            if ({frame_step, len_clk, sweep_clk, env_clk} !== 6'd0) begin
                bad++;
                $display("FAIL reset_state got=%b want=000000", {frame_step, len_clk, sweep_clk, env_clk});
            end
        end
        // release with div_bit low: no tick
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        total++;
        if ({frame_step, len_clk} !== 4'd0) begin
            bad++;
            $display("FAIL reset_release got step=%0d len=%b want step=0 len=0", frame_step, len_clk);
        end
    endtask

    task automatic test_sequence;
        int nlen = 0, nsw = 0, nenv = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
            total++;
            if ({len_clk, sweep_clk, env_clk} !== 3'b000) begin
                bad++;
                $display("FAIL seq_quiet step=%0d got=%b want=000", i, {len_clk, sweep_clk, env_clk});
            end
            drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
            nlen += int'(len_clk); nsw += int'(sweep_clk); nenv += int'(env_clk);
            total++;
            if (frame_step !== 3'(i + 1) || len_clk !== len_tab[i] || sweep_clk !== sweep_tab[i]
                || env_clk !== env_tab[i] || len_next_n !== 1'((i + 1) % 2)) begin
                bad++;
                $display("FAIL seq_tick i=%0d got step=%0d l/s/e=%b%b%b n=%b want step=%0d l/s/e=%b%b%b",
                         i, frame_step, len_clk, sweep_clk, env_clk, len_next_n,
                         (i + 1) % 8, len_tab[i], sweep_tab[i], env_tab[i]);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        total++;
        if ({len_clk, sweep_clk, env_clk} !== 3'b000) begin
            bad++;
            $display("FAIL seq_width got=%b want=000", {len_clk, sweep_clk, env_clk});
        end
        total++;
        if (nlen != 4 || nsw != 2 || nenv != 1) begin
            bad++;
            $display("FAIL seq_counts got len=%0d sweep=%0d env=%0d want 4 2 1", nlen, nsw, nenv);
        end
    endtask

    task automatic test_level;
        int changes = 0;
        int start = m_step;
        logic [2:0] prev = frame_step;
        for (int i = 0; i < 200; i++) begin
            drive(1'b1, (i < 100), 1'b0, 1'b0, 3'd0);
            if (frame_step !== prev) changes++;
            prev = frame_step;
        end
        total++;
        if (changes != 1 || frame_step !== 3'((start + 1) % 8)) begin
            bad++;
            $display("FAIL level_one_tick got changes=%0d step=%0d want 1 step=%0d",
                     changes, frame_step, (start + 1) % 8);
        end
    endtask

    task automatic test_enable_drop;
        for (int i = 0; i < 8 && m_step != 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
            drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        end
        total++;
        if (frame_step !== 3'd5) begin
            bad++;
            $display("FAIL en_reach5 got=%0d want=5", frame_step);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);   // enable falls in the tick cycle
        total++;
        if ({frame_step, len_clk, sweep_clk, env_clk} !== 6'd0) begin
            bad++;
            $display("FAIL en_drop got=%b want=000000", {frame_step, len_clk, sweep_clk, env_clk});
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
            drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
            total++;
            if ({frame_step, len_clk, sweep_clk, env_clk} !== 6'd0) begin
                bad++;
                $display("FAIL en_off_edge%0d got=%b want=000000", i, {frame_step, len_clk, sweep_clk, env_clk});
            end
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);   // first enabled cycle is a tick
        total++;
        if (frame_step !== 3'd1 || len_clk !== 1'b1 || sweep_clk !== 1'b0 || env_clk !== 1'b0) begin
            bad++;
            $display("FAIL en_resume got step=%0d l/s/e=%b%b%b want step=1 l/s/e=100",
                     frame_step, len_clk, sweep_clk, env_clk);
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 8 && m_step != 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
            drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);   // reset in tick cycle at step 6
        total++;
        if ({frame_step, len_clk, sweep_clk, env_clk} !== 6'd0) begin
            bad++;
            $display("FAIL rst_mid got=%b want=000000", {frame_step, len_clk, sweep_clk, env_clk});
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        total++;
        if ({frame_step, len_clk} !== 4'd0) begin
            bad++;
            $display("FAIL rst_mid_release got step=%0d len=%b want 0 0", frame_step, len_clk);
        end
    endtask

`ifdef FRAME_SEQ_STEP_WR_EN
    task automatic test_step_wr;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd7);   // load collides with a tick
        total++;
        if ({frame_step, len_clk, sweep_clk, env_clk} !== {3'd7, 3'b000}) begin
            bad++;
            $display("FAIL wr_load got=%b want=111000", {frame_step, len_clk, sweep_clk, env_clk});
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        total++;
        if (env_clk !== 1'b1 || frame_step !== 3'd0 || len_next_n !== 1'b0 || len_clk !== 1'b0) begin
            bad++;
            $display("FAIL wr_next got env=%b step=%0d n=%b len=%b want 1 0 0 0",
                     env_clk, frame_step, len_next_n, len_clk);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b1, 3'd3);   // load while disabled
        total++;
        if (frame_step !== 3'd3) begin
            bad++;
            $display("FAIL wr_disabled got=%0d want=3", frame_step);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        total++;
        if (frame_step !== 3'd0) begin
            bad++;
            $display("FAIL wr_disabled_next got=%0d want=0", frame_step);
        end
    endtask
`endif

    task automatic test_random;
        bit dv = m_prev_div;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) dv = !dv;
            drive($urandom_range(0, 9) != 0, dv, $urandom_range(0, 99) == 0,
                  $urandom_range(0, 49) == 0, 3'($urandom_range(0, 7)));
            total++;
            if ({frame_step, len_clk, sweep_clk, env_clk, len_next_n}
                !== {3'(m_step), e_len, e_sweep, e_env, 1'(m_step % 2)}) begin
                bad++;
                $display("FAIL rand_cyc%0d got step=%0d l/s/e=%b%b%b n=%b want step=%0d l/s/e=%b%b%b n=%b",
                         i, frame_step, len_clk, sweep_clk, env_clk, len_next_n,
                         m_step, e_len, e_sweep, e_env, 1'(m_step % 2));
            end
        end
    endtask

    initial begin
        apu_reset = 1'b1;
        apu_en    = 1'b0;
        div_bit   = 1'b0;
        step_wr   = 1'b0;
        step_d    = 3'd0;
        test_reset();
        test_sequence();
        test_level();
        test_enable_drop();
        test_reset_mid();
`ifdef FRAME_SEQ_STEP_WR_EN
        test_step_wr();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
